conv33_ctrl: RTL
================

CONV33_CTRL -- requirements
Module: conv33_ctrl

Interface
REQ-001 Parameter IMG_W, default 28, input feature-map width in pixels (>=3).
REQ-002 Parameter IMG_H, default 28, input feature-map height in pixels (>=3).
REQ-003 Parameter CALC_LAT, default 4, conv33_calc latency from conv33_en to valid, in cycles.
REQ-004 Parameter CNT_W, default 10, width of row/col/result counters.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rst, input, 1, reset; synchronous and active-high.
REQ-007 Port start, input, 1, pulse to begin one frame.
REQ-008 Port stall, input, 1, downstream backpressure; freezes window issue.
REQ-009 Port calc_valid, input, 1, valid from conv33_calc.
REQ-010 Port busy, output, 1, high from accepted start until done.
REQ-011 Port done, output, 1, one-cycle pulse when the frame completes.
REQ-012 Port wload_en / wload_idx, output, 1 / 4, weight-register load strobe and index 0..8.
REQ-013 Port win_req / win_row / win_col, output, 1 / CNT_W / CNT_W, window-fetch request and top-left pixel coordinate.
REQ-014 Port conv33_en, output, 1, enable to conv33_calc.
REQ-015 Port res_last, output, 1, high with the calc_valid of the final result.
REQ-016 Port err, output, 1, sticky protocol-error flag.

Function
REQ-017 FSM states IDLE, LOAD_W, RUN, DRAIN, DONE; the IDLE->LOAD_W transition occurs on start, and the state encoding is defined in the package.
REQ-018 LOAD_W: wload_en high for exactly 9 consecutive cycles with wload_idx 0,1,...,8; the state then goes to RUN.
REQ-019 RUN: while stall=0, one win_req per cycle; col steps 0..IMG_W-3, then wraps to 0 with row+1; row covers 0..IMG_H-3.
REQ-020 stall=1: no win_req; win_row/win_col hold; scanning resumes at the held coordinate when stall=0.
REQ-021 conv33_en = win_req delayed by exactly 1 cycle (line-buffer read latency).
REQ-022 After issuing window (IMG_H-3, IMG_W-3), the FSM goes to DRAIN.
REQ-023 Result counter increments on each calc_valid; total = (IMG_W-2)*(IMG_H-2).
REQ-024 res_last is high in the cycle calc_valid brings the count to the total.
REQ-025 DRAIN: the FSM waits for res_last, then goes to DONE.
REQ-026 DONE: done=1 for one cycle, busy drops the same cycle, and the FSM returns to IDLE.
REQ-027 start while busy is ignored, with no restart and no error.
REQ-028 err is set when calc_valid arrives in IDLE, or when more than CALC_LAT+1 results are outstanding; it is cleared only by rst.
REQ-029 start and rst in the same cycle: rst wins.
REQ-030 stall during LOAD_W or DRAIN has no effect; calc_valid is counted regardless of stall.

Reset
REQ-031 rst sets the state to IDLE; all counters to 0; busy, done, wload_en, win_req, conv33_en, res_last and err to 0; wload_idx, win_row and win_col to 0.
REQ-032 rst mid-frame aborts immediately; no done pulse is produced; late calc_valid after rst is not counted and does not set err for CALC_LAT+1 cycles.

Structure
REQ-033 Shared package conv33_pkg holds the FSM state typedef, the KERNEL_TAPS=9 constant and the default CALC_LAT.
REQ-034 One sub-module, conv33_scan_cnt (row/col scan counter with enable, wrap and last flag); the rest is flat.

Verification
REQ-035 IMG_W=5, IMG_H=5, stall=0, start pulse -> 9 wload_en cycles (idx 0..8), then 9 win_req at (0,0),(0,1),(0,2),(1,0)...(2,2), with conv33_en 1 cycle after each.
REQ-036 Same config with calc_valid modelled at CALC_LAT=4 -> res_last on the 9th result, done 1 cycle later, busy low with done, err=0.
REQ-037 stall=1 for 3 cycles after the 4th win_req -> win_row/win_col hold at (1,1), then resume; the total is still 9 win_req with no duplicates.
REQ-038 rst asserted during RUN at window (1,0) -> next cycle all outputs 0, state IDLE, no done; a new start replays the frame from LOAD_W.
REQ-039 start pulsed again while busy, and calc_valid injected in IDLE -> the restart is ignored and err=1 stays set until rst.

Source files
------------

// File: rtl/conv33_pkg.sv
// rtl/conv33_pkg.sv - shared types and constants for the 3x3 convolution controller
package conv33_pkg;

  localparam int KERNEL_TAPS  = 9;
  localparam int CALC_LAT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } conv33_state_e;

endpackage

// File: rtl/conv33_scan_cnt.sv
// rtl/conv33_scan_cnt.sv - raster row/col counter over the valid 3x3 window origins
module conv33_scan_cnt #(
  parameter int NCOL  = 26,
  parameter int NROW  = 26,
  parameter int CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(NCOL - 1);
  localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(NROW - 1);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic             col_wrap;

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == ROW_MAX) && (col_q == COL_MAX);

  always_comb begin
    col_wrap = (col_q == COL_MAX);
    row_d    = row_q;
    col_d    = col_q;
    if (en_i) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv33_ctrl.sv
// rtl/conv33_ctrl.sv - frame sequencer: weight load, window scan, result drain
module conv33_ctrl
  import conv33_pkg::*;
#(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int CALC_LAT = CALC_LAT_DEF,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             calc_valid,
  output logic             busy,
  output logic             done,
  output logic             wload_en,
  output logic [3:0]       wload_idx,
  output logic             win_req,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             conv33_en,
  output logic             res_last,
  output logic             err
);

  localparam logic [3:0]       TAP_LAST  = 4'(KERNEL_TAPS - 1);
  localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'((IMG_W - 2) * (IMG_H - 2) - 1);
  localparam logic [CNT_W-1:0] OUT_MAX   = CNT_W'(CALC_LAT + 1);
  localparam int               IGN_W     = $clog2(CALC_LAT + 2);
  localparam logic [IGN_W-1:0] IGN_INIT  = IGN_W'(CALC_LAT + 1);

  conv33_state_e    state_q;
  logic [3:0]       tap_q;
  logic [CNT_W-1:0] res_cnt_q;
  logic [CNT_W-1:0] out_q, out_d;
  logic [IGN_W-1:0] ign_q;
  logic             conv_en_q;
  logic             err_q;

  logic start_acc;
  logic scan_last;
  logic res_valid;
  logic out_dec;
  logic idle_hit;
  logic err_hit;

  always_comb begin
    busy      = (state_q == ST_LOAD_W) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done      = (state_q == ST_DONE);
    wload_en  = (state_q == ST_LOAD_W);
    wload_idx = tap_q;
    win_req   = (state_q == ST_RUN) && !stall;
    conv33_en = conv_en_q;
    err       = err_q;
    start_acc = (state_q == ST_IDLE) && start;
    // Results still in flight from an aborted frame are swallowed for CALC_LAT+1 cycles after rst.
    res_valid = calc_valid && busy && (ign_q == '0);
    idle_hit  = calc_valid && (state_q == ST_IDLE) && (ign_q == '0);
    res_last  = res_valid && (res_cnt_q == RES_LAST);
    out_dec   = res_valid && ((out_q != '0) || conv_en_q);
    out_d     = out_q + CNT_W'(conv_en_q) - CNT_W'(out_dec);
    err_hit   = idle_hit || (out_d > OUT_MAX);
  end

  conv33_scan_cnt #(
    .NCOL  (IMG_W - 2),
    .NROW  (IMG_H - 2),
    .CNT_W (CNT_W)
  ) u_scan (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (start_acc),
    .en_i   (win_req),
    .row_o  (win_row),
    .col_o  (win_col),
    .last_o (scan_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tap_q     <= '0;
      res_cnt_q <= '0;
      out_q     <= '0;
      conv_en_q <= 1'b0;
      err_q     <= 1'b0;
      ign_q     <= IGN_INIT;
    end else begin
      conv_en_q <= win_req;
      out_q     <= out_d;
      if (res_valid) res_cnt_q <= res_cnt_q + CNT_W'(1);
      if (ign_q != '0) ign_q <= ign_q - IGN_W'(1);
      if (err_hit) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LOAD_W;
            tap_q     <= '0;
            res_cnt_q <= '0;
            out_q     <= '0;
          end
        end
        ST_LOAD_W: begin
          if (tap_q == TAP_LAST) begin
            state_q <= ST_RUN;
            tap_q   <= '0;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        ST_RUN: begin
          if (win_req && scan_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (res_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
